// File: rtl/branch_ctrl_pkg.sv
// branch_ctrl_pkg: shared state encoding, forward codes and helpers for branch resolution
package branch_ctrl_pkg;
  typedef logic [1:0] fwd_t;
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_WAIT    = 2'd1;
  localparam logic [1:0] ST_RESOLVE = 2'd2;
  localparam fwd_t FWD_RF  = 2'b00;
  localparam fwd_t FWD_MEM = 2'b01;
  localparam fwd_t FWD_WB  = 2'b10;
  function automatic logic [1:0] max2(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction
endpackage

// File: rtl/branch_resolve_ctrl_if.sv
// branch_resolve_ctrl_if: pipeline-side signals seen by the ID-stage branch resolver
interface branch_resolve_ctrl_if #(parameter int STAT_W = 16);
  import branch_ctrl_pkg::*;
  logic id_valid, id_is_beq, id_is_bne;
  logic [4:0] id_rs, id_rt;
  logic ex_reg_write, ex_mem_read;
  logic [4:0] ex_rd;
  logic mem_reg_write, mem_mem_read;
  logic [4:0] mem_rd;
  logic wb_reg_write;
  logic [4:0] wb_rd;
  logic cmp_eq;
  fwd_t fwd_a_sel, fwd_b_sel;
  logic stall, flush_if_id, pc_src;
  logic [STAT_W-1:0] br_count, br_taken_count;
  modport master (
    output id_valid, id_is_beq, id_is_bne, id_rs, id_rt,
    output ex_reg_write, ex_mem_read, ex_rd,
    output mem_reg_write, mem_mem_read, mem_rd,
    output wb_reg_write, wb_rd, cmp_eq,
    input  fwd_a_sel, fwd_b_sel, stall, flush_if_id, pc_src, br_count, br_taken_count
  );
  modport slave (
    input  id_valid, id_is_beq, id_is_bne, id_rs, id_rt,
    input  ex_reg_write, ex_mem_read, ex_rd,
    input  mem_reg_write, mem_mem_read, mem_rd,
    input  wb_reg_write, wb_rd, cmp_eq,
    output fwd_a_sel, fwd_b_sel, stall, flush_if_id, pc_src, br_count, br_taken_count
  );
endinterface

// File: rtl/branch_fwd_sel.sv
// branch_fwd_sel: hazard class (cycles to wait) and forward source for one compare operand
module branch_fwd_sel
  import branch_ctrl_pkg::*;
(
  input  logic [4:0] rs,
  input  logic       ex_reg_write,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rd,
  input  logic       mem_reg_write,
  input  logic       mem_mem_read,
  input  logic [4:0] mem_rd,
  input  logic       wb_reg_write,
  input  logic [4:0] wb_rd,
  output logic [1:0] haz,
  output fwd_t       sel
);
  logic ex_hit, mem_hit, wb_hit;
  always_comb begin
    ex_hit  = (rs != 5'd0) && (ex_rd == rs);
    mem_hit = (rs != 5'd0) && (mem_rd == rs);
    wb_hit  = (rs != 5'd0) && (wb_rd == rs);
    haz = (ex_hit && ex_mem_read) ? 2'd2 :
          ((ex_hit && ex_reg_write) || (mem_hit && mem_mem_read)) ? 2'd1 : 2'd0;
    sel = (mem_hit && mem_reg_write && !mem_mem_read) ? FWD_MEM :
          (wb_hit && wb_reg_write) ? FWD_WB : FWD_RF;
  end
endmodule

// File: rtl/branch_resolve_ctrl.sv
// branch_resolve_ctrl: ID-stage branch resolution with hazard stalls, forwarding and statistics
module branch_resolve_ctrl
  import branch_ctrl_pkg::*;
#(
  parameter int STAT_W = 16
) (
  input  logic clk,
  input  logic rst_n,
  branch_resolve_ctrl_if.slave bus
);
  logic [1:0] state, state_nx, wait_cnt, wait_nx, haz_a, haz_b, haz;
  fwd_t sel_a, sel_b;
  logic br, resolve, taken, stall_i;
  logic [STAT_W-1:0] br_cnt, tk_cnt;
  branch_fwd_sel u_fwd_a (
    .rs(bus.id_rs), .ex_reg_write(bus.ex_reg_write), .ex_mem_read(bus.ex_mem_read), .ex_rd(bus.ex_rd),
    .mem_reg_write(bus.mem_reg_write), .mem_mem_read(bus.mem_mem_read), .mem_rd(bus.mem_rd),
    .wb_reg_write(bus.wb_reg_write), .wb_rd(bus.wb_rd), .haz(haz_a), .sel(sel_a)
  );
  branch_fwd_sel u_fwd_b (
    .rs(bus.id_rt), .ex_reg_write(bus.ex_reg_write), .ex_mem_read(bus.ex_mem_read), .ex_rd(bus.ex_rd),
    .mem_reg_write(bus.mem_reg_write), .mem_mem_read(bus.mem_mem_read), .mem_rd(bus.mem_rd),
    .wb_reg_write(bus.wb_reg_write), .wb_rd(bus.wb_rd), .haz(haz_b), .sel(sel_b)
  );
  always_comb begin
    br = bus.id_valid && (bus.id_is_beq || bus.id_is_bne);
    haz = max2(haz_a, haz_b);
    state_nx = state;
    wait_nx = wait_cnt;
    stall_i = 1'b0;
    resolve = 1'b0;
    case (state)
      ST_IDLE: begin
        resolve = br && (haz == 2'd0);
        if (br && haz != 2'd0) begin
          stall_i = 1'b1;
          wait_nx = haz;
          // a one-cycle hazard has already reached 1 on load, so it skips WAIT
          state_nx = (haz == 2'd1) ? ST_RESOLVE : ST_WAIT;
        end
      end
      ST_WAIT: begin
        stall_i = bus.id_valid;
        wait_nx = bus.id_valid ? wait_cnt - 2'd1 : 2'd0;
        state_nx = !bus.id_valid ? ST_IDLE : (wait_cnt <= 2'd2) ? ST_RESOLVE : ST_WAIT;
      end
      ST_RESOLVE: begin
        resolve = br;
        wait_nx = 2'd0;
        state_nx = ST_IDLE;
      end
      default: begin
        wait_nx = 2'd0;
        state_nx = ST_IDLE;
      end
    endcase
    taken = resolve && (bus.id_is_beq ? bus.cmp_eq : !bus.cmp_eq);
    bus.stall = rst_n && stall_i;
    bus.pc_src = rst_n && taken;
    bus.flush_if_id = rst_n && taken;
    bus.fwd_a_sel = rst_n ? sel_a : FWD_RF;
    bus.fwd_b_sel = rst_n ? sel_b : FWD_RF;
    bus.br_count = br_cnt;
    bus.br_taken_count = tk_cnt;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      wait_cnt <= 2'd0;
      br_cnt <= '0;
      tk_cnt <= '0;
    end else begin
      state <= state_nx;
      wait_cnt <= wait_nx;
      if (resolve && br_cnt != '1) br_cnt <= br_cnt + 1'b1;
      if (taken && tk_cnt != '1) tk_cnt <= tk_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// tb_branch_resolve_ctrl: directed scenarios plus randomized traffic checked against a stall-budget model
module tb_branch_resolve_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int tests = 0;
  int fails = 0;
  bit armed = 1'b0;
  branch_resolve_ctrl_if #(.STAT_W(16)) bus();
  branch_resolve_ctrl_if #(.STAT_W(4)) bus4();
  branch_resolve_ctrl #(.STAT_W(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  branch_resolve_ctrl #(.STAT_W(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
  assign bus4.id_valid = bus.id_valid;
  assign bus4.id_is_beq = bus.id_is_beq;
  assign bus4.id_is_bne = bus.id_is_bne;
  assign bus4.id_rs = bus.id_rs;
  assign bus4.id_rt = bus.id_rt;
  assign bus4.ex_reg_write = bus.ex_reg_write;
  assign bus4.ex_mem_read = bus.ex_mem_read;
  assign bus4.ex_rd = bus.ex_rd;
  assign bus4.mem_reg_write = bus.mem_reg_write;
  assign bus4.mem_mem_read = bus.mem_mem_read;
  assign bus4.mem_rd = bus.mem_rd;
  assign bus4.wb_reg_write = bus.wb_reg_write;
  assign bus4.wb_rd = bus.wb_rd;
  assign bus4.cmp_eq = bus.cmp_eq;
  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, got, exp, $time);
    end
  endtask

  // stall cycles owed by an operand: a producer in EX needs one cycle to reach MEM,
  // a load in EX two cycles to reach WB, a load in MEM one cycle
  function automatic int need(input logic [4:0] r);
    if (r == 0) return 0;
    if (bus.ex_rd == r && bus.ex_mem_read) return 2;
    if (bus.ex_rd == r && bus.ex_reg_write) return 1;
    if (bus.mem_rd == r && bus.mem_mem_read) return 1;
    return 0;
  endfunction

  function automatic logic [1:0] src(input logic [4:0] r);
    if (r == 0) return 2'b00;
    if (bus.mem_rd == r && bus.mem_reg_write && !bus.mem_mem_read) return 2'b01;
    if (bus.wb_rd == r && bus.wb_reg_write) return 2'b10;
    return 2'b00;
  endfunction

  bit m_busy = 0;
  int m_left = 0;
  int m_cnt = 0, m_tk = 0, m_cnt4 = 0, m_tk4 = 0;

  always @(negedge clk) begin
    bit br, res, tk, st, busy_n;
    int left_n, h;
    logic [1:0] fa, fb;
    br = bus.id_valid && (bus.id_is_beq || bus.id_is_bne);
    st = 0; res = 0; fa = 2'b00; fb = 2'b00;
    busy_n = m_busy; left_n = m_left;
    if (rst_n) begin
      fa = src(bus.id_rs);
      fb = src(bus.id_rt);
      if (!m_busy) begin
        h = (need(bus.id_rs) > need(bus.id_rt)) ? need(bus.id_rs) : need(bus.id_rt);
        if (br && h == 0) res = 1;
        else if (br) begin st = 1; busy_n = 1; left_n = h - 1; end
      end else if (m_left > 0) begin
        if (!bus.id_valid) busy_n = 0;
        else begin st = 1; left_n = m_left - 1; end
      end else begin
        res = br;
        busy_n = 0;
      end
    end
    tk = res && (bus.id_is_beq ? bus.cmp_eq : !bus.cmp_eq);
    if (armed) begin
      chk("stall", 32'(bus.stall), 32'(st));
      chk("pc_src", 32'(bus.pc_src), 32'(tk));
      chk("flush_if_id", 32'(bus.flush_if_id), 32'(tk));
      chk("fwd_a_sel", 32'(bus.fwd_a_sel), 32'(fa));
      chk("fwd_b_sel", 32'(bus.fwd_b_sel), 32'(fb));
      chk("br_count", 32'(bus.br_count), m_cnt);
      chk("br_taken_count", 32'(bus.br_taken_count), m_tk);
      chk("br_count4", 32'(bus4.br_count), m_cnt4);
      chk("br_taken_count4", 32'(bus4.br_taken_count), m_tk4);
    end
    if (!rst_n) begin
      m_busy = 0; m_left = 0; m_cnt = 0; m_tk = 0; m_cnt4 = 0; m_tk4 = 0;
    end else begin
      m_busy = busy_n; m_left = left_n;
      if (res) begin m_cnt = (m_cnt < 65535) ? m_cnt + 1 : m_cnt; m_cnt4 = (m_cnt4 < 15) ? m_cnt4 + 1 : m_cnt4; end
      if (tk) begin m_tk = (m_tk < 65535) ? m_tk + 1 : m_tk; m_tk4 = (m_tk4 < 15) ? m_tk4 + 1 : m_tk4; end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear;
    bus.id_valid = 0; bus.id_is_beq = 0; bus.id_is_bne = 0; bus.id_rs = 0; bus.id_rt = 0;
    bus.ex_reg_write = 0; bus.ex_mem_read = 0; bus.ex_rd = 0;
    bus.mem_reg_write = 0; bus.mem_mem_read = 0; bus.mem_rd = 0;
    bus.wb_reg_write = 0; bus.wb_rd = 0; bus.cmp_eq = 0;
  endtask

  task automatic branch(input bit beq, input logic [4:0] rs, input logic [4:0] rt, input bit eq);
    bus.id_valid = 1; bus.id_is_beq = beq; bus.id_is_bne = !beq;
    bus.id_rs = rs; bus.id_rt = rt; bus.cmp_eq = eq;
  endtask

  initial begin
    clear();
    rst_n = 0;
    tick();
    armed = 1;
    tick();
    rst_n = 1;
    @(negedge clk);
    chk("reset_stall", 32'(bus.stall), 0);
    chk("reset_count", 32'(bus.br_count), 0);
    tick();
    // BEQ, no hazards: same-cycle taken
    branch(1, 3, 3, 1);
    @(negedge clk);
    chk("beq_stall", 32'(bus.stall), 0);
    chk("beq_pc_src", 32'(bus.pc_src), 1);
    chk("beq_flush", 32'(bus.flush_if_id), 1);
    tick(); clear();
    @(negedge clk);
    chk("beq_count", 32'(bus.br_count), 1);
    chk("beq_taken", 32'(bus.br_taken_count), 1);
    tick();
    // BNE behind an ALU producer of r5
    branch(0, 5, 1, 1); bus.ex_reg_write = 1; bus.ex_rd = 5;
    @(negedge clk);
    chk("bne_stall", 32'(bus.stall), 1);
    chk("bne_pc_hold", 32'(bus.pc_src), 0);
    tick(); clear(); branch(0, 5, 1, 1); bus.mem_reg_write = 1; bus.mem_rd = 5;
    @(negedge clk);
    chk("bne_res_stall", 32'(bus.stall), 0);
    chk("bne_fwd_a", 32'(bus.fwd_a_sel), 1);
    chk("bne_pc_src", 32'(bus.pc_src), 0);
    tick(); clear();
    @(negedge clk);
    chk("bne_count", 32'(bus.br_count), 2);
    chk("bne_taken", 32'(bus.br_taken_count), 1);
    tick();
    // BEQ behind a load of r7
    branch(1, 2, 7, 0); bus.ex_reg_write = 1; bus.ex_mem_read = 1; bus.ex_rd = 7;
    @(negedge clk);
    chk("ld_stall1", 32'(bus.stall), 1);
    tick(); clear(); branch(1, 2, 7, 0); bus.mem_reg_write = 1; bus.mem_mem_read = 1; bus.mem_rd = 7;
    @(negedge clk);
    chk("ld_stall2", 32'(bus.stall), 1);
    tick(); clear(); branch(1, 2, 7, 0); bus.wb_reg_write = 1; bus.wb_rd = 7;
    @(negedge clk);
    chk("ld_res_stall", 32'(bus.stall), 0);
    chk("ld_fwd_b", 32'(bus.fwd_b_sel), 2);
    chk("ld_pc_src", 32'(bus.pc_src), 0);
    tick(); clear();
    @(negedge clk);
    chk("ld_count", 32'(bus.br_count), 3);
    chk("ld_taken", 32'(bus.br_taken_count), 1);
    tick();
    // reset while waiting on a load
    branch(1, 2, 7, 1); bus.ex_reg_write = 1; bus.ex_mem_read = 1; bus.ex_rd = 7;
    @(negedge clk);
    chk("rw_stall", 32'(bus.stall), 1);
    tick(); rst_n = 0;
    @(negedge clk);
    chk("rw_rst_stall", 32'(bus.stall), 0);
    chk("rw_rst_pc", 32'(bus.pc_src), 0);
    tick(); rst_n = 1; clear();
    @(negedge clk);
    chk("rw_idle_stall", 32'(bus.stall), 0);
    chk("rw_count", 32'(bus.br_count), 0);
    chk("rw_taken", 32'(bus.br_taken_count), 0);
    tick();
    // r0 never hazards or forwards
    branch(1, 0, 0, 1); bus.ex_reg_write = 1; bus.ex_mem_read = 1;
    bus.mem_reg_write = 1; bus.wb_reg_write = 1;
    @(negedge clk);
    chk("r0_stall", 32'(bus.stall), 0);
    chk("r0_fwd_a", 32'(bus.fwd_a_sel), 0);
    chk("r0_fwd_b", 32'(bus.fwd_b_sel), 0);
    chk("r0_pc_src", 32'(bus.pc_src), 1);
    tick(); clear();
    // saturation of the 4-bit instance
    rst_n = 0; tick(); rst_n = 1;
    for (int i = 0; i < 17; i++) begin
      branch(1, 3, 3, 1);
      tick();
    end
    clear();
    @(negedge clk);
    chk("sat4_count", 32'(bus4.br_count), 15);
    chk("sat4_taken", 32'(bus4.br_taken_count), 15);
    chk("sat16_count", 32'(bus.br_count), 17);
    tick();
    for (int i = 0; i < 3000; i++) begin
      rst_n = ($urandom_range(0, 49) != 0);
      bus.id_valid = ($urandom_range(0, 7) != 0);
      case ($urandom_range(0, 2))
        0: begin bus.id_is_beq = 0; bus.id_is_bne = 0; end
        1: begin bus.id_is_beq = 1; bus.id_is_bne = 0; end
        default: begin bus.id_is_beq = 0; bus.id_is_bne = 1; end
      endcase
      bus.id_rs = 5'($urandom_range(0, 3));
      bus.id_rt = 5'($urandom_range(0, 3));
      bus.ex_reg_write = 1'($urandom_range(0, 1));
      bus.ex_mem_read = 1'($urandom_range(0, 1));
      bus.ex_rd = 5'($urandom_range(0, 3));
      bus.mem_reg_write = 1'($urandom_range(0, 1));
      bus.mem_mem_read = 1'($urandom_range(0, 1));
      bus.mem_rd = 5'($urandom_range(0, 3));
      bus.wb_reg_write = 1'($urandom_range(0, 1));
      bus.wb_rd = 5'($urandom_range(0, 3));
      bus.cmp_eq = 1'($urandom_range(0, 1));
      tick();
    end
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
